// File: rtl/hazard_fwd_unit.sv
// -----------------------------------------------------------------------------
// hazard_fwd_unit
//
// Purpose:
//   Operand forwarding and issue control between decode/register-file read and
//   Execute. A scoreboard of FWD_DEPTH entries tracks the destination register
//   of every instruction in the post-issue stages (stage 0 = EX, stage
//   FWD_DEPTH-1 = WB). Each issuing source operand is taken from the youngest
//   in-flight producer of that register when its result is available. If that
//   producer's result is not available yet, issue stalls. If no producer is in
//   flight, the register-file read data is used. Resolved operands are
//   registered into the EX stage one cycle after an accepted issue.
//
// Parameters:
//   XLEN       datapath width
//   AW         register address width (x0 reads as zero, never written)
//   FWD_DEPTH  tracked post-issue stages, legal range 1..8
//
// Ports:
//   i_clk            clock, rising edge
//   i_rst_n          asynchronous active-low reset
//   i_iss_vld        decode presents an instruction
//   i_iss_rs1/2      source register addresses
//   i_iss_rs1/2_use  source is actually read
//   i_iss_rd         destination register
//   i_iss_rd_wen     instruction writes rd
//   i_rf_rddata1/2   register-file read data for rs1/rs2 (same cycle)
//   i_res_vld        bit s: stage-s result available this cycle
//   i_res_data       slice s: stage-s result
//   i_hold           global freeze
//   i_flush          drop the instruction currently issuing
//   o_iss_rdy        issue accepted this cycle (combinational)
//   o_ex_vld         EX-stage operands valid (registered)
//   o_ex_x_rs1/2     forwarded operands (registered)
//   o_stall_cnt      issue-stall cycle counter
//
// Optional feature (macro HFU_PERF_CNT_EN):
//   Defined   -> o_stall_cnt counts stalled issue cycles, saturating.
//   Undefined -> o_stall_cnt is tied to zero and no counter is built.
// -----------------------------------------------------------------------------
module hazard_fwd_unit #(
  parameter int XLEN      = 32,
  parameter int AW        = 5,
  parameter int FWD_DEPTH = 3
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_iss_vld,
  input  logic [AW-1:0]             i_iss_rs1,
  input  logic [AW-1:0]             i_iss_rs2,
  input  logic                      i_iss_rs1_use,
  input  logic                      i_iss_rs2_use,
  input  logic [AW-1:0]             i_iss_rd,
  input  logic                      i_iss_rd_wen,
  input  logic [XLEN-1:0]           i_rf_rddata1,
  input  logic [XLEN-1:0]           i_rf_rddata2,
  input  logic [FWD_DEPTH-1:0]      i_res_vld,
  input  logic [FWD_DEPTH*XLEN-1:0] i_res_data,
  input  logic                      i_hold,
  input  logic                      i_flush,
  output logic                      o_iss_rdy,
  output logic                      o_ex_vld,
  output logic [XLEN-1:0]           o_ex_x_rs1,
  output logic [XLEN-1:0]           o_ex_x_rs2,
  output logic [31:0]               o_stall_cnt
);

  // Result of looking one source register up in the scoreboard.
  typedef struct packed {
    logic            hit;   // some in-flight instruction writes this register
    logic            rdy;   // the youngest such producer has its result now
    logic [XLEN-1:0] data;  // that producer's result
  } lookup_t;

  // ---------------------------------------------------------------------------
  // Scoreboard: entry s describes the instruction currently in stage s.
  // r_sb_wen is stored already qualified with rd != 0, so x0 never matches.
  // ---------------------------------------------------------------------------
  logic [FWD_DEPTH-1:0]         r_sb_vld;
  logic [FWD_DEPTH-1:0]         r_sb_wen;
  logic [FWD_DEPTH-1:0][AW-1:0] r_sb_rd;

  logic            r_ex_vld;
  logic [XLEN-1:0] r_ex_x_rs1;
  logic [XLEN-1:0] r_ex_x_rs2;

  lookup_t         w_lk1;
  lookup_t         w_lk2;
  logic            w_haz1;
  logic            w_haz2;
  logic [XLEN-1:0] w_op1;
  logic [XLEN-1:0] w_op2;
  logic            w_iss_rdy;
  logic            w_new_wen;

  // Scan from the oldest stage towards stage 0, so a younger producer
  // overwrites an older one and the lowest matching stage wins.
  function automatic lookup_t lookup(input logic [AW-1:0] rs);
    lookup_t r;
    r = '0;
    for (int s = FWD_DEPTH - 1; s >= 0; s--) begin
      if (r_sb_vld[s] && r_sb_wen[s] && (r_sb_rd[s] == rs)) begin
        r.hit  = 1'b1;
        r.rdy  = i_res_vld[s];
        r.data = i_res_data[s*XLEN +: XLEN];
      end
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Operand resolution
  // ---------------------------------------------------------------------------
  always_comb begin
    w_lk1 = lookup(i_iss_rs1);
    w_lk2 = lookup(i_iss_rs2);
  end

  // A source hazards only if it is really read, is not x0, and its youngest
  // producer has not produced yet.
  assign w_haz1 = i_iss_rs1_use && (i_iss_rs1 != '0) && w_lk1.hit && !w_lk1.rdy;
  assign w_haz2 = i_iss_rs2_use && (i_iss_rs2 != '0) && w_lk2.hit && !w_lk2.rdy;

  always_comb begin
    w_op1 = i_rf_rddata1;
    if (i_iss_rs1 == '0) begin
      w_op1 = '0;
    end else if (w_lk1.hit && w_lk1.rdy) begin
      w_op1 = w_lk1.data;
    end
  end

  always_comb begin
    w_op2 = i_rf_rddata2;
    if (i_iss_rs2 == '0) begin
      w_op2 = '0;
    end else if (w_lk2.hit && w_lk2.rdy) begin
      w_op2 = w_lk2.data;
    end
  end

  // Flush wins over everything: the issuing instruction is dropped, and decode
  // re-presents the jump target.
  assign w_iss_rdy = i_iss_vld && !i_hold && !i_flush && !w_haz1 && !w_haz2;
  assign w_new_wen = i_iss_rd_wen && (i_iss_rd != '0);

  // ---------------------------------------------------------------------------
  // Scoreboard shift and EX-stage registers. Hold freezes everything.
  // The last entry falls off here. The register file must write before it
  // reads, so that the retiring value is visible to the next reader.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sb_vld <= '0;
      r_sb_wen <= '0;
      r_sb_rd  <= '0;
    end else if (!i_hold) begin
      for (int s = FWD_DEPTH - 1; s > 0; s--) begin
        r_sb_vld[s] <= r_sb_vld[s-1];
        r_sb_wen[s] <= r_sb_wen[s-1];
        r_sb_rd[s]  <= r_sb_rd[s-1];
      end
      if (w_iss_rdy) begin
        r_sb_vld[0] <= 1'b1;
        r_sb_wen[0] <= w_new_wen;
        r_sb_rd[0]  <= i_iss_rd;
      end else begin
        r_sb_vld[0] <= 1'b0;
        r_sb_wen[0] <= 1'b0;
        r_sb_rd[0]  <= '0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ex_vld   <= 1'b0;
      r_ex_x_rs1 <= '0;
      r_ex_x_rs2 <= '0;
    end else if (!i_hold) begin
      r_ex_vld <= w_iss_rdy;
      if (w_iss_rdy) begin
        r_ex_x_rs1 <= w_op1;
        r_ex_x_rs2 <= w_op2;
      end else begin
        r_ex_x_rs1 <= '0;
        r_ex_x_rs2 <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stall counter: counts cycles where a live instruction could not issue
  // because of a hazard. Flushed and held cycles are not stalls.
  // ---------------------------------------------------------------------------
`ifdef HFU_PERF_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cnt <= '0;
    end else if (!i_hold && i_iss_vld && !i_flush && !w_iss_rdy &&
                 (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
`else
  assign o_stall_cnt = '0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_iss_rdy  = w_iss_rdy;
  assign o_ex_vld   = r_ex_vld;
  assign o_ex_x_rs1 = r_ex_x_rs1;
  assign o_ex_x_rs2 = r_ex_x_rs2;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit. It runs directed scenarios first and then random
// traffic. All of it is checked against an in-flight instruction list model.
module tb_hazard_fwd_unit;
  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int D    = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              iss_vld;
  logic [AW-1:0]     iss_rs1, iss_rs2, iss_rd;
  logic              iss_rs1_use, iss_rs2_use, iss_rd_wen;
  logic [XLEN-1:0]   rf1, rf2;
  logic [D-1:0]      res_vld;
  logic [D*XLEN-1:0] res_data;
  logic              hold, flush;
  logic              iss_rdy, ex_vld;
  logic [XLEN-1:0]   ex_x_rs1, ex_x_rs2;
  logic [31:0]       stall_cnt;

  always #5 clk = ~clk;

  hazard_fwd_unit #(.XLEN(XLEN), .AW(AW), .FWD_DEPTH(D)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_iss_vld(iss_vld), .i_iss_rs1(iss_rs1), .i_iss_rs2(iss_rs2),
    .i_iss_rs1_use(iss_rs1_use), .i_iss_rs2_use(iss_rs2_use),
    .i_iss_rd(iss_rd), .i_iss_rd_wen(iss_rd_wen),
    .i_rf_rddata1(rf1), .i_rf_rddata2(rf2),
    .i_res_vld(res_vld), .i_res_data(res_data),
    .i_hold(hold), .i_flush(flush),
    .o_iss_rdy(iss_rdy), .o_ex_vld(ex_vld),
    .o_ex_x_rs1(ex_x_rs1), .o_ex_x_rs2(ex_x_rs2),
    .o_stall_cnt(stall_cnt)
  );

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  // Reference model: a list of in-flight instructions indexed by age since
  // issue (index 0 = issued last cycle).
  typedef struct {
    bit          live;
    bit          writes;
    bit [AW-1:0] dest;
  } inst_t;

  inst_t     m_pipe[D];
  bit        m_ex_vld;
  bit [31:0] m_ex1, m_ex2, m_stall;
  bit        m_use1, m_use2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < D; i++) m_pipe[i] = '{live: 1'b0, writes: 1'b0, dest: '0};
    m_ex_vld = 0; m_ex1 = 0; m_ex2 = 0; m_stall = 0;
  endfunction

  // Youngest live writer of rs supplies the value if its result is on the bus.
  function automatic void resolve(input bit [AW-1:0] rs, input bit use_, input bit [31:0] rf,
                                  output bit haz, output bit [31:0] val);
    haz = 0;
    val = rf;
    if (rs == 0) begin
      val = 0;
      return;
    end
    for (int age = 0; age < D; age++) begin
      if (m_pipe[age].live && m_pipe[age].writes && m_pipe[age].dest == rs) begin
        if (res_vld[age]) val = res_data[age*XLEN +: XLEN];
        else haz = use_;
        return;
      end
    end
  endfunction

  task automatic idle();
    iss_vld = 0; iss_rs1 = 0; iss_rs2 = 0; iss_rs1_use = 0; iss_rs2_use = 0;
    iss_rd = 0; iss_rd_wen = 0; rf1 = 0; rf2 = 0;
    res_vld = 0; res_data = 0; hold = 0; flush = 0;
  endtask

  task automatic present(input bit [AW-1:0] rs1, input bit u1, input bit [AW-1:0] rs2,
                         input bit u2, input bit [AW-1:0] rd, input bit wen,
                         input bit [31:0] d1, input bit [31:0] d2);
    iss_vld = 1; iss_rs1 = rs1; iss_rs1_use = u1; iss_rs2 = rs2; iss_rs2_use = u2;
    iss_rd = rd; iss_rd_wen = wen; rf1 = d1; rf2 = d2;
  endtask

  // Called right after an active edge with inputs already driven. The bench
  // checks iss_rdy mid-cycle, advances the model, and checks the registered
  // outputs just after the next edge.
  task automatic cycle(input string tag);
    bit h1, h2, exp_rdy;
    bit [31:0] v1, v2;
    #2;
    resolve(iss_rs1, iss_rs1_use, rf1, h1, v1);
    resolve(iss_rs2, iss_rs2_use, rf2, h2, v2);
    exp_rdy = iss_vld && !hold && !flush && !h1 && !h2;
    chk({tag, ".iss_rdy"}, 32'(iss_rdy), 32'(exp_rdy));
    if (!hold) begin
`ifdef HFU_PERF_CNT_EN
      if (iss_vld && !flush && !exp_rdy && m_stall != 32'hFFFF_FFFF) m_stall++;
`endif
      for (int a = D - 1; a > 0; a--) m_pipe[a] = m_pipe[a-1];
      if (exp_rdy) m_pipe[0] = '{live: 1'b1, writes: iss_rd_wen && iss_rd != 0, dest: iss_rd};
      else m_pipe[0] = '{live: 1'b0, writes: 1'b0, dest: '0};
      m_ex_vld = exp_rdy;
      m_ex1 = exp_rdy ? v1 : 0;
      m_ex2 = exp_rdy ? v2 : 0;
      m_use1 = iss_rs1_use || iss_rs1 == 0;
      m_use2 = iss_rs2_use || iss_rs2 == 0;
    end
    @(posedge clk);
    #1;
    chk({tag, ".ex_vld"}, 32'(ex_vld), 32'(m_ex_vld));
    if (!m_ex_vld || m_use1) chk({tag, ".ex_x_rs1"}, ex_x_rs1, m_ex1);
    if (!m_ex_vld || m_use2) chk({tag, ".ex_x_rs2"}, ex_x_rs2, m_ex2);
    chk({tag, ".stall_cnt"}, stall_cnt, m_stall);
  endtask

  initial begin
    bit [31:0] s0;
    idle();
    model_reset();
    rst_n = 0;
    #3;
    chk("rst.ex_vld", 32'(ex_vld), 32'd0);
    chk("rst.ex_x_rs1", ex_x_rs1, 32'd0);
    chk("rst.stall_cnt", stall_cnt, 32'd0);
    #9 rst_n = 1;
    @(posedge clk);
    #1;

    // EX forward: x5 produced in stage 0 with its result ready.
    present(0, 0, 0, 0, 5, 1, 0, 0);
    cycle("exfwd_prod");
    present(5, 1, 0, 0, 1, 1, 32'h0, 0);
    res_vld = 3'b001; res_data = '0; res_data[0 +: XLEN] = 32'h7;
    cycle("exfwd_cons");
    chk("exfwd.val", ex_x_rs1, 32'h7);
    idle();

    // Youngest priority: x3 in stage 2 and in stage 0.
    present(0, 0, 0, 0, 3, 1, 0, 0); cycle("young_p0");
    present(0, 0, 0, 0, 9, 1, 0, 0); cycle("young_p1");
    present(0, 0, 0, 0, 3, 1, 0, 0); cycle("young_p2");
    present(0, 0, 3, 1, 4, 1, 0, 32'h55);
    res_vld = 3'b101; res_data = '0;
    res_data[2*XLEN +: XLEN] = 32'h11; res_data[0 +: XLEN] = 32'h22;
    cycle("young_cons");
    chk("young.val", ex_x_rs2, 32'h22);
    idle();

    // Load-use: one stall cycle, then forward from stage 1.
    s0 = m_stall;
    present(0, 0, 0, 0, 8, 1, 0, 0); cycle("ld_prod");
    present(8, 1, 0, 0, 10, 1, 32'hDEAD, 0);
    res_vld = 3'b010; res_data = '0; res_data[XLEN +: XLEN] = 32'hAB;
    cycle("ld_stall");
    chk("ld.bubble", 32'(ex_vld), 32'd0);
`ifdef HFU_PERF_CNT_EN
    chk("ld.stall_cnt", stall_cnt, s0 + 32'd1);
`else
    chk("ld.stall_cnt", stall_cnt, 32'd0);
`endif
    cycle("ld_go");
    chk("ld.val", ex_x_rs1, 32'hAB);
    idle();

    // x0 producer and consumer, then flush.
    present(0, 0, 0, 0, 0, 1, 0, 0); cycle("x0_prod");
    present(0, 1, 0, 0, 11, 1, 32'hDEAD, 0); cycle("x0_cons");
    chk("x0.val", ex_x_rs1, 32'h0);
    present(0, 0, 0, 0, 13, 1, 0, 0); flush = 1;
    cycle("flush");
    chk("flush.ex_vld", 32'(ex_vld), 32'd0);
    idle();

    // Hold for three cycles with a pending hazard.
    present(0, 0, 0, 0, 12, 1, 0, 0); cycle("hold_prod");
    present(12, 1, 0, 0, 14, 1, 0, 0); res_vld = 3'b000; hold = 1;
    cycle("hold1"); cycle("hold2"); cycle("hold3");
    hold = 0; cycle("hold_resume_stall");
    res_vld = 3'b010; res_data = {32'h0, 32'hC3, 32'h0};
    cycle("hold_resume_go");
    chk("hold.val", ex_x_rs1, 32'hC3);
    idle();

    // Reset mid-operation: three issues fill the scoreboard, ex_vld is high.
    present(0, 0, 0, 0, 1, 1, 0, 0); cycle("fill0");
    present(0, 0, 0, 0, 2, 1, 0, 0); cycle("fill1");
    present(0, 0, 0, 0, 3, 1, 0, 0); cycle("fill2");
    chk("fill.ex_vld", 32'(ex_vld), 32'd1);
    rst_n = 0;
    #1;
    chk("arst.ex_vld", 32'(ex_vld), 32'd0);
    chk("arst.ex_x_rs1", ex_x_rs1, 32'd0);
    chk("arst.ex_x_rs2", ex_x_rs2, 32'd0);
    chk("arst.stall_cnt", stall_cnt, 32'd0);
    model_reset();
    #1 rst_n = 1;
    present(1, 1, 3, 1, 6, 1, 32'h1234, 32'h5678);
    cycle("post_rst");
    chk("post_rst.val", ex_x_rs2, 32'h5678);
    idle();

    // Random traffic on a small register window, so that hits are frequent.
    for (int n = 0; n < 600; n++) begin
      iss_vld     = ($urandom_range(0, 9) < 8);
      iss_rs1     = AW'($urandom_range(0, 3));
      iss_rs2     = AW'($urandom_range(0, 3));
      iss_rs1_use = $urandom_range(0, 1);
      iss_rs2_use = $urandom_range(0, 1);
      iss_rd      = AW'($urandom_range(0, 3));
      iss_rd_wen  = ($urandom_range(0, 3) != 0);
      rf1         = $urandom;
      rf2         = $urandom;
      res_vld     = D'($urandom);
      res_data    = {$urandom, $urandom, $urandom};
      hold        = ($urandom_range(0, 9) == 0);
      flush       = ($urandom_range(0, 9) == 0);
      cycle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
Parametrised successor to the core's fixed one-stage operand-forwarding and control path. It tracks in-flight destination registers across FWD_DEPTH post-issue stages (EX..WB) and forwards the youngest ready result to the issuing instruction. It stalls issue on load-use or any not-yet-ready producer, inserts bubbles on flush, and registers the resolved operands into the EX stage. It sits between decode/register-file read and Execute.

Parameters:
XLEN, 32, datapath width
AW, 5, register address width (2**AW architectural registers; x0 hard-zero)
FWD_DEPTH, 3, tracked stages after issue (stage 0 = EX, FWD_DEPTH-1 = WB); legal 1..8

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
iss_vld  in  1  decode presents an instruction
iss_rs1, iss_rs2  in  AW  source register addresses
iss_rs1_use, iss_rs2_use  in  1  source actually read
iss_rd  in  AW  destination register
iss_rd_wen  in  1  instruction writes rd
rf_rddata1, rf_rddata2  in  XLEN  register-file read data for iss_rs1/iss_rs2, same cycle
res_vld  in  FWD_DEPTH  bit s: result of the stage-s instruction is available this cycle
res_data  in  FWD_DEPTH*XLEN  slice s: stage-s result
hold  in  1  global freeze (memory busy)
flush  in  1  kill the instruction currently issuing (taken jump resolved)
iss_rdy  out  1  issue accepted this cycle (combinational)
ex_vld  out  1  registered: EX-stage operands valid
ex_x_rs1, ex_x_rs2  out  XLEN  registered forwarded operands
stall_cnt  out  32  issue-stall cycle counter (optional feature)

Behaviour:
- Reset (rst=0, async): all scoreboard entries invalid; ex_vld=0; ex_x_rs1=ex_x_rs2=0; stall_cnt=0.
- Scoreboard: FWD_DEPTH entries {vld, rd, wen}. Entry s describes the instruction in stage s.
- Each cycle with hold=0, entries shift s to s+1 and entry FWD_DEPTH-1 retires. Entry 0 loads the issued instruction, or a bubble (vld=0) when not issuing.
- hold=1: scoreboard, ex_* and stall_cnt frozen; iss_rdy=0.
- Operand resolution per source (rsN_use=1, rsN!=0): select the lowest s with vld & wen & rd==rsN.
  - Match with res_vld[s]=1: operand = res_data[s].
  - Match with res_vld[s]=0: hazard.
  - No match: operand = rf_rddata.
- Sources with rsN_use=0 or rsN=0 never hazard. The operand is forced to 0 when rsN=0.
- iss_rdy = iss_vld & !hold & !flush & !hazard_rs1 & !hazard_rs2.
- On the edge with iss_rdy=1: ex_vld<=1, ex_x_rsN<=resolved value, and entry 0 <= {1, iss_rd, iss_rd_wen & iss_rd!=0}.
- On the edge with hold=0 and iss_rdy=0: ex_vld<=0, ex_x_rs* <= 0, bubble inserted.
- Flush takes priority over hazard. The flushed instruction is dropped; decode must re-present the jump target. Existing entries still shift.
- Latency: one cycle from accepted issue to ex_* valid. A producer in stage s with res_vld[s]=1 forwards with zero extra stall.
- Load-use: a load in stage 0 has res_vld[0]=0, so a dependent instruction stalls until the load reaches a stage where res_vld asserts.
- A producer retiring past WB leaves the scoreboard. The register file must already hold its value, so write-before-read is required in the register file.
- Simultaneous iss_vld and an outstanding hazard: stall; iss_* must be held stable by decode until iss_rdy.

Optional Feature:
HFU_PERF_CNT_EN
- Defined: stall_cnt increments by 1 on each non-hold cycle with iss_vld=1, flush=0 and iss_rdy=0. It saturates at 32'hFFFF_FFFF.
- Undefined: stall_cnt is tied to 0 and no counter logic is present.

Test Plan:
- Reset mid-operation: scoreboard full, ex_vld=1; drop rst asynchronously -> ex_vld=0, ex_x_rs*=0 before the next edge; after release an independent issue is accepted at once.
- EX forward: issue x5 <= 7 (rd=5), res_vld[0]=1, res_data[0]=7; next cycle issue rs1=5 with rf_rddata1=0 -> iss_rdy=1, ex_x_rs1=7 next edge.
- Youngest priority: rd=3 in stage 2 (data 0x11) and stage 0 (data 0x22), both ready; issue rs2=3 -> ex_x_rs2=0x22.
- Load-use: load rd=8 in stage 0 with res_vld[0]=0, res_vld[1]=1 data 0xAB; dependent rs1=8 -> iss_rdy=0 for 1 cycle, ex_vld=0 bubble, then ex_x_rs1=0xAB; with HFU_PERF_CNT_EN stall_cnt=1.
- x0/flush: rd=0 producer then rs1=0 consumer -> no stall, ex_x_rs1=0; flush=1 with iss_vld=1 -> iss_rdy=0, ex_vld=0, entry 0 bubble, stall_cnt unchanged.
- Hold: hold=1 for 3 cycles with pending hazard -> ex_*, scoreboard and stall_cnt unchanged; resume matches the cycle-accurate reference model.
